// File: rtl/soc_cfg_pkg.sv
// Shared SoC DMA configuration: request/burst descriptors, burst-depth default and AXI constants.
package soc_cfg_pkg;

  localparam int DMA_MAX_BURST_BEATS = 16;
  localparam int AXI_4K_BOUNDARY     = 4096;

  localparam int DMA_ADDR_W = 64;
  localparam int DMA_LEN_W  = 32;
  localparam int DMA_ID_W   = 4;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
  } dma_req_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [DMA_ID_W-1:0]   id;
    logic                  last;
  } dma_burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/soc_dma_rr_arb.sv
// Round-robin arbiter: grants the lowest-indexed request at or above the pointer, wrapping;
// the pointer moves past the granted channel when advance_i is strobed.
module soc_dma_rr_arb #(
  parameter int N_CH = 1,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] req_i,
  input  logic            advance_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o
);

  localparam logic [N_CH-1:0] ONE = 1;

  logic [CH_W-1:0] r_rr;
  logic [N_CH-1:0] w_mask;
  logic [N_CH-1:0] w_masked;
  logic [N_CH-1:0] w_lo_masked;
  logic [N_CH-1:0] w_lo_any;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
    assign w_mask[gi] = (CH_W'(gi) >= r_rr);
  end

  // Prefer requests at/above the pointer; fall back to the lowest one overall.
  assign w_masked    = req_i & w_mask;
  assign w_lo_masked = w_masked & (~w_masked + ONE);
  assign w_lo_any    = req_i & (~req_i + ONE);
  assign gnt_o       = (|w_masked) ? w_lo_masked : w_lo_any;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_o[i]) idx_o = CH_W'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else if (advance_i) begin
      r_rr <= (idx_o == CH_W'(N_CH - 1)) ? '0 : idx_o + CH_W'(1);
    end
  end

endmodule

// File: rtl/soc_dma_burst_splitter.sv
// Multi-channel DMA burst splitter: one linear request at a time, cut into AXI bursts of at most
// MAX_BURST_BEATS beats that never cross 4 KiB. Define SOC_DMA_SPLIT_PERF_CNT_EN for perf counters.
module soc_dma_burst_splitter
  import soc_cfg_pkg::*;
#(
  parameter int N_CH            = 1,
  parameter int AXI_AW          = 64,
  parameter int AXI_DW          = 64,
  parameter int ID_W            = 4,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST_BEATS = DMA_MAX_BURST_BEATS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_CH-1:0]              req_valid_i,
  output logic [N_CH-1:0]              req_ready_o,
  input  logic [N_CH-1:0][AXI_AW-1:0]  req_addr_i,
  input  logic [N_CH-1:0][LEN_W-1:0]   req_len_i,
  output logic                         burst_valid_o,
  input  logic                         burst_ready_i,
  output logic [AXI_AW-1:0]            burst_addr_o,
  output logic [7:0]                   burst_len_o,
  output logic [ID_W-1:0]              burst_id_o,
  output logic                         burst_last_o,
  output logic [N_CH-1:0]              done_o
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_bursts_o,
  output logic [31:0]                  perf_stall_o
`endif
);

  localparam int BPB      = AXI_DW / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [AXI_AW-1:0] ADDR_MASK = ~AXI_AW'(BPB - 1);

  if (!is_pow2(MAX_BURST_BEATS) || MAX_BURST_BEATS > 256) begin : g_bad_max
    $error("MAX_BURST_BEATS must be a power of 2 in 1..256");
  end
  if (!is_pow2(BPB)) begin : g_bad_dw
    $error("AXI_DW/8 must be a power of 2");
  end
  if (N_CH > (2 ** ID_W)) begin : g_bad_id
    $error("N_CH must not exceed 2**ID_W");
  end

  // Beats for the next burst: capped by what remains, the burst depth and the 4 KiB page end.
  function automatic logic [8:0] f_beats(input logic [11:0] a_lo, input logic [LEN_W-1:0] rem);
    logic [12:0]      to_4k;
    logic [LEN_W-1:0] lim;
    to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, a_lo};
    lim   = LEN_W'(to_4k >> BPB_LOG2);
    if (LEN_W'(MAX_BURST_BEATS) < lim) lim = LEN_W'(MAX_BURST_BEATS);
    if (rem < lim) lim = rem;
    return 9'(lim);
  endfunction

  split_state_e     r_state;
  logic [AXI_AW-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_rem_beats;
  logic [CH_W-1:0]   r_ch;
  logic              r_burst_valid;
  logic [7:0]        r_burst_len;
  logic [ID_W-1:0]   r_burst_id;
  logic              r_burst_last;
  logic [N_CH-1:0]   r_done;

  logic [N_CH-1:0]   w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_idle;
  logic              w_req_fire;
  logic              w_burst_fire;
  logic [AXI_AW-1:0] w_sel_addr;
  logic [LEN_W-1:0]  w_sel_len;
  logic [AXI_AW-1:0] w_acc_addr;
  logic [LEN_W-1:0]  w_acc_beats;
  logic [8:0]        w_acc_nb;
  logic [8:0]        w_cur_nb;
  logic [AXI_AW-1:0] w_nxt_addr;
  logic [LEN_W-1:0]  w_nxt_rem;
  logic [8:0]        w_nxt_nb;
  logic [N_CH-1:0]   w_ch_onehot;

  soc_dma_rr_arb #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (w_req_fire),
    .gnt_o     (w_gnt),
    .idx_o     (w_gnt_idx)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr_i[i];
        w_sel_len  = req_len_i[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_done_sel
    assign w_ch_onehot[gi] = (r_ch == CH_W'(gi));
  end

  assign w_idle       = (r_state == ST_IDLE);
  assign w_req_fire   = w_idle & (|req_valid_i);
  assign w_burst_fire = r_burst_valid & burst_ready_i;
  assign req_ready_o  = w_gnt & {N_CH{w_idle & ~rst_i}};

  assign w_acc_addr  = w_sel_addr & ADDR_MASK;
  assign w_acc_beats = w_sel_len >> BPB_LOG2;
  assign w_acc_nb    = f_beats(w_acc_addr[11:0], w_acc_beats);

  assign w_cur_nb   = f_beats(r_cur_addr[11:0], r_rem_beats);
  assign w_nxt_addr = r_cur_addr + (AXI_AW'(w_cur_nb) << BPB_LOG2);
  assign w_nxt_rem  = r_rem_beats - LEN_W'(w_cur_nb);
  assign w_nxt_nb   = f_beats(w_nxt_addr[11:0], w_nxt_rem);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_rem_beats   <= '0;
      r_ch          <= '0;
      r_burst_valid <= 1'b0;
      r_burst_len   <= '0;
      r_burst_id    <= '0;
      r_burst_last  <= 1'b0;
      r_done        <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_ch        <= w_gnt_idx;
            r_cur_addr  <= w_acc_addr;
            r_rem_beats <= w_acc_beats;
            if (w_acc_beats == '0) begin
              r_done <= w_gnt;
            end else begin
              r_state       <= ST_SPLIT;
              r_burst_valid <= 1'b1;
              r_burst_len   <= 8'(w_acc_nb - 9'd1);
              r_burst_id    <= ID_W'(w_gnt_idx);
              r_burst_last  <= (LEN_W'(w_acc_nb) == w_acc_beats);
            end
          end
        end
        ST_SPLIT: begin
          if (w_burst_fire) begin
            if (r_burst_last) begin
              // Keep the address/len of the final burst on the bus; only valid drops.
              r_state       <= ST_IDLE;
              r_burst_valid <= 1'b0;
              r_rem_beats   <= '0;
              r_done        <= w_ch_onehot;
            end else begin
              r_cur_addr   <= w_nxt_addr;
              r_rem_beats  <= w_nxt_rem;
              r_burst_len  <= 8'(w_nxt_nb - 9'd1);
              r_burst_last <= (LEN_W'(w_nxt_nb) == w_nxt_rem);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign burst_valid_o = r_burst_valid;
  assign burst_addr_o  = r_cur_addr;
  assign burst_len_o   = r_burst_len;
  assign burst_id_o    = r_burst_id;
  assign burst_last_o  = r_burst_last;
  assign done_o        = r_done;

`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
  logic [31:0] r_perf_bursts;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_bursts <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_burst_fire) r_perf_bursts <= r_perf_bursts + 32'd1;
      if (r_burst_valid & ~burst_ready_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_bursts_o = r_perf_bursts;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_soc_dma_burst_splitter.sv
// Directed bench for soc_dma_burst_splitter with two channels and default burst geometry.
module tb_soc_dma_burst_splitter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][63:0] req_addr;
  logic [1:0][31:0] req_len;
  logic             burst_valid;
  logic             burst_ready;
  logic [63:0]      burst_addr;
  logic [7:0]       burst_len;
  logic [3:0]       burst_id;
  logic             burst_last;
  logic [1:0]       done;
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
  logic [31:0]      perf_bursts;
  logic [31:0]      perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  soc_dma_burst_splitter #(
    .N_CH            (2),
    .AXI_AW          (64),
    .AXI_DW          (64),
    .ID_W            (4),
    .LEN_W           (32),
    .MAX_BURST_BEATS (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .burst_valid_o (burst_valid),
    .burst_ready_i (burst_ready),
    .burst_addr_o  (burst_addr),
    .burst_len_o   (burst_len),
    .burst_id_o    (burst_id),
    .burst_last_o  (burst_last),
    .done_o        (done)
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
    ,
    .perf_bursts_o (perf_bursts),
    .perf_stall_o  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                             input logic [3:0] id, input logic last);
    check({tag, "_valid"}, 64'(burst_valid), 64'd1);
    check({tag, "_addr"}, burst_addr, addr);
    check({tag, "_len"}, 64'(burst_len), 64'(len));
    check({tag, "_id"}, 64'(burst_id), 64'(id));
    check({tag, "_last"}, 64'(burst_last), 64'(last));
    $display("burst %s: addr=%0h len=%0d id=%0d last=%0d", tag, burst_addr, burst_len, burst_id, burst_last);
  endtask

  initial begin
    // Reset state, with a request already pending.
    rst = 1'b1; req_valid = 2'b01; req_addr = '0; req_len = '0; burst_ready = 1'b0;
    #2;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(burst_valid), 64'd0);
    check("rst_addr", burst_addr, 64'd0);
    check("rst_len", 64'(burst_len), 64'd0);
    check("rst_id", 64'(burst_id), 64'd0);
    check("rst_last", 64'(burst_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick(); tick();
    rst = 1'b0; req_valid = 2'b00;

    // ch0 0x1000, 256 B -> two 16-beat bursts.
    req_valid = 2'b01; req_addr[0] = 64'h1000; req_len[0] = 32'd256;
    #1; check("t1_ready", 64'(req_ready), 64'b01);
    tick(); req_valid = 2'b00; burst_ready = 1'b1;
    check_burst("t1_b0", 64'h1000, 8'd15, 4'd0, 1'b0);
    tick(); check_burst("t1_b1", 64'h1080, 8'd15, 4'd0, 1'b1);
    tick(); check("t1_done", 64'(done), 64'b01);
    check("t1_idle_valid", 64'(burst_valid), 64'd0);
    tick(); check("t1_done_clr", 64'(done), 64'd0);

    // 4 KiB boundary: 0x0FC0, 128 B -> 8 beats up to 0x1000, then 8 more.
    req_valid = 2'b01; req_addr[0] = 64'h0FC0; req_len[0] = 32'd128;
    #1; check("t2_ready", 64'(req_ready), 64'b01);
    tick(); req_valid = 2'b00;
    check_burst("t2_b0", 64'h0FC0, 8'd7, 4'd0, 1'b0);
    tick(); check_burst("t2_b1", 64'h1000, 8'd7, 4'd0, 1'b1);
    tick(); check("t2_done", 64'(done), 64'b01);

    // Sub-beat and zero lengths complete without any burst.
    req_valid = 2'b10; req_addr[1] = 64'h20; req_len[1] = 32'd7;
    #1; check("t3_ready_a", 64'(req_ready), 64'b10);
    tick(); req_valid = 2'b00;
    check("t3_done_a", 64'(done), 64'b10);
    check("t3_valid_a", 64'(burst_valid), 64'd0);
    tick(); check("t3_done_a_clr", 64'(done), 64'd0);
    req_valid = 2'b10; req_len[1] = 32'd0;
    #1; check("t3_ready_b", 64'(req_ready), 64'b10);
    tick(); req_valid = 2'b00;
    check("t3_done_b", 64'(done), 64'b10);
    check("t3_valid_b", 64'(burst_valid), 64'd0);
    tick();

    // Both channels valid: grants alternate 0, 1, 0.
    req_valid = 2'b11; req_addr[0] = 64'h2000; req_len[0] = 32'd64;
    req_addr[1] = 64'h3000; req_len[1] = 32'd64;
    #1; check("t4_ready0", 64'(req_ready), 64'b01);
    tick(); check("t4_split_ready", 64'(req_ready), 64'd0);
    check_burst("t4_g0", 64'h2000, 8'd7, 4'd0, 1'b1);
    tick(); check("t4_done0", 64'(done), 64'b01);
    check("t4_ready1", 64'(req_ready), 64'b10);
    tick(); check_burst("t4_g1", 64'h3000, 8'd7, 4'd1, 1'b1);
    tick(); check("t4_done1", 64'(done), 64'b10);
    check("t4_ready2", 64'(req_ready), 64'b01);
    tick(); check_burst("t4_g2", 64'h2000, 8'd7, 4'd0, 1'b1);
    req_valid = 2'b00;
    tick(); check("t4_done2", 64'(done), 64'b01);
    tick();

    // Back-pressure for 5 cycles: burst fields hold.
    burst_ready = 1'b0;
    req_valid = 2'b10; req_addr[1] = 64'h4000; req_len[1] = 32'd64;
    #1; check("t5_ready", 64'(req_ready), 64'b10);
    tick(); req_valid = 2'b00;
    check_burst("t5_b0", 64'h4000, 8'd7, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(); check_burst("t5_hold", 64'h4000, 8'd7, 4'd1, 1'b1);
    end
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
    check("t5_perf_stall", 64'(perf_stall), 64'd5);
`endif
    burst_ready = 1'b1;
    tick(); check("t5_done", 64'(done), 64'b10);
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
    check("t5_perf_bursts", 64'(perf_bursts), 64'd8);
`endif
    tick();

    // Reset in the middle of a 512 B request.
    req_valid = 2'b01; req_addr[0] = 64'h5000; req_len[0] = 32'd512;
    #1; check("t6_ready", 64'(req_ready), 64'b01);
    tick(); req_valid = 2'b00;
    check_burst("t6_b0", 64'h5000, 8'd15, 4'd0, 1'b0);
    tick(); check_burst("t6_b1", 64'h5080, 8'd15, 4'd0, 1'b0);
    rst = 1'b1; req_valid = 2'b10;
    #1;
    check("t6_rst_valid", 64'(burst_valid), 64'd0);
    check("t6_rst_addr", burst_addr, 64'd0);
    check("t6_rst_len", 64'(burst_len), 64'd0);
    check("t6_rst_last", 64'(burst_last), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
`ifdef SOC_DMA_SPLIT_PERF_CNT_EN
    check("t6_rst_perf", 64'(perf_bursts), 64'd0);
`endif
    tick(); rst = 1'b0; req_valid = 2'b00;
    #1; check("t6_post_done", 64'(done), 64'd0);
    check("t6_post_valid", 64'(burst_valid), 64'd0);
    req_valid = 2'b11; req_addr[0] = 64'h6000; req_len[0] = 32'd64;
    req_addr[1] = 64'h7000; req_len[1] = 32'd64;
    #1; check("t6_rr_fresh", 64'(req_ready), 64'b01);
    tick(); req_valid = 2'b00;
    check_burst("t6_new", 64'h6000, 8'd7, 4'd0, 1'b1);
    tick(); check("t6_new_done", 64'(done), 64'b01);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
